prio_encoder_rr: RTL and testbench



---
 rtl/prio_encoder_rr_if.sv | 25 ++
 rtl/prio_encoder_rr.sv | 93 +++++++++
 tb/tb_prio_encoder_rr.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/prio_encoder_rr_if.sv
// Request/result bundle for prio_encoder_rr: request side and encoded-index side, each valid/ready.
interface prio_encoder_rr_if #(
  parameter int N = 16
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  req_in;
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] idx_out;
  logic          none_out;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output req_in, mode, in_valid, out_ready,
    input  in_ready, idx_out, none_out, out_valid
  );

  modport slave (
    input  req_in, mode, in_valid, out_ready,
    output in_ready, idx_out, none_out, out_valid
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// Registered N-to-log2(N) priority encoder, fixed (highest index) or round-robin; latency 1 cycle,
// single output register, in_ready = !out_valid || out_ready. Macro ONEHOT_CHECK_EN adds multi_hot_out.
module prio_encoder_rr #(
  parameter int N = 16
) (
  input  logic clk,
  input  logic rst_n,
  prio_encoder_rr_if.slave bus
`ifdef ONEHOT_CHECK_EN
  ,
  output logic multi_hot_out
`endif
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] fix_idx;
  logic [IW-1:0] rr_idx;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ptr_nxt;
  logic          any_req;
  logic          rr_found;
  logic          accept;
  logic [IW-1:0] idx_q;
  logic          none_q;
  logic          valid_q;

  assign any_req     = |bus.req_in;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept      = bus.in_valid && bus.in_ready;

  // Highest set bit wins in fixed mode: later iterations overwrite earlier ones.
  always_comb begin
    fix_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.req_in[i]) fix_idx = IW'(i);
    end
  end

  // Scan from ptr upward, wrapping at N (N need not be a power of two).
  always_comb begin
    int j;
    rr_idx   = '0;
    rr_found = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!rr_found && bus.req_in[j]) begin
        rr_idx   = IW'(j);
        rr_found = 1'b1;
      end
    end
  end

  always_comb begin
    win_idx = '0;
    if (any_req) win_idx = bus.mode ? rr_idx : fix_idx;
    ptr_nxt = (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      none_q  <= 1'b0;
      ptr     <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        idx_q   <= win_idx;
        none_q  <= !any_req;
        if (bus.mode && any_req) ptr <= ptr_nxt;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ONEHOT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      multi_hot_out <= 1'b0;
    end else if (accept) begin
      multi_hot_out <= |(bus.req_in & (bus.req_in - 1'b1));
    end
  end
`endif

  assign bus.idx_out   = idx_q;
  assign bus.none_out  = none_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_prio_encoder_rr.sv
// Directed bench for prio_encoder_rr with an expected-result queue filled on accept, drained on output.
module tb_prio_encoder_rr;
  localparam int N  = 16;
  localparam int IW = $clog2(N);

  typedef struct {
    logic [IW-1:0] idx;
    logic          none;
    logic          multi;
  } exp_t;

  logic clk;
  logic rst_n;
  prio_encoder_rr_if #(.N(N)) bus ();
`ifdef ONEHOT_CHECK_EN
  logic multi_hot_out;
`endif

  prio_encoder_rr #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ONEHOT_CHECK_EN
    ,
    .multi_hot_out (multi_hot_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors;
  int   miscompares;
  exp_t sb[$];
  exp_t last;
  int   m_ptr;
  logic m_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: fixed = scan downward from N-1; round-robin = first hit of (ptr+k) mod N.
  function automatic exp_t model(input logic [N-1:0] r, input logic m);
    exp_t e;
    int   cnt;
    e.idx  = '0;
    e.none = (r == '0);
    cnt    = 0;
    for (int i = 0; i < N; i++) cnt += int'(r[i]);
    e.multi = (cnt > 1);
    if (!e.none) begin
      if (!m) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (r[i]) begin
            e.idx = IW'(i);
            break;
          end
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            e.idx = IW'((m_ptr + k) % N);
            break;
          end
        end
      end
    end
    return e;
  endfunction

  task automatic check_hold();
    check("idx_out", 32'(bus.idx_out), 32'(last.idx));
    check("none_out", 32'(bus.none_out), 32'(last.none));
`ifdef ONEHOT_CHECK_EN
    check("multi_hot_out", 32'(multi_hot_out), 32'(last.multi));
`endif
  endtask

  task automatic step(input logic [N-1:0] r, input logic m, input logic v, input logic ordy);
    logic acc;
    exp_t e;
    @(negedge clk);
    bus.req_in    = r;
    bus.mode      = m;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    acc = v && (!m_valid || ordy);
    if (acc) begin
      e = model(r, m);
      sb.push_back(e);
      if (m && !e.none) m_ptr = (int'(e.idx) + 1) % N;
    end
    @(posedge clk);
    #1;
    if (acc) begin
      if (sb.size() == 0) begin
        miscompares++;
        $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
        last = sb.pop_front();
      end
      m_valid = 1'b1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    check_hold();
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr      = 0;
    m_valid    = 1'b0;
    last.idx   = '0;
    last.none  = 1'b0;
    last.multi = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_reset();
    bus.req_in    = '0;
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_hold();
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed priority and all-zero
    step(16'h8421, 1'b0, 1'b1, 1'b1);
    check("fixed_8421", 32'(bus.idx_out), 32'd15);
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    check("fixed_zero_none", 32'(bus.none_out), 32'd1);

    // Round-robin rotation and wrap
    step(16'h0011, 1'b1, 1'b1, 1'b1);
    check("rr_first", 32'(bus.idx_out), 32'd0);
    step(16'h0011, 1'b1, 1'b1, 1'b1);
    check("rr_second", 32'(bus.idx_out), 32'd4);
    step(16'h0011, 1'b1, 1'b1, 1'b1);
    step(16'h8000, 1'b1, 1'b1, 1'b1);
    check("rr_wrap_idx", 32'(bus.idx_out), 32'd15);
    step(16'h0011, 1'b1, 1'b1, 1'b1);
    check("rr_after_wrap", 32'(bus.idx_out), 32'd0);
    step(16'h0000, 1'b1, 1'b1, 1'b1);
    step(16'h0011, 1'b1, 1'b1, 1'b1);
    check("rr_zero_keeps_ptr", 32'(bus.idx_out), 32'd4);

    // Back-pressure: result 4 held for 3 cycles, then fixed-mode accept
    for (int c = 0; c < 3; c++) step(16'h0002, 1'b0, 1'b1, 1'b0);
    step(16'h0002, 1'b0, 1'b1, 1'b1);
    check("bp_release", 32'(bus.idx_out), 32'd1);
    step(16'h0021, 1'b1, 1'b1, 1'b1);
    check("ptr_kept_over_fixed", 32'(bus.idx_out), 32'd5);

    // Drain with no accept: out_valid drops, data holds
    step(16'hFFFF, 1'b1, 1'b0, 1'b1);
    step(16'h0010, 1'b1, 1'b1, 1'b1);
    check("rr_wrap_scan", 32'(bus.idx_out), 32'd4);

    // Asynchronous reset between edges with ptr=5 and a held result
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_out_valid", 32'(bus.out_valid), 32'd0);
    check_hold();
    @(negedge clk);
    rst_n = 1'b1;
    step(16'h0021, 1'b1, 1'b1, 1'b1);
    check("ptr_reset", 32'(bus.idx_out), 32'd0);

`ifdef ONEHOT_CHECK_EN
    step(16'h0003, 1'b0, 1'b1, 1'b1);
    check("onehot_multi", 32'(multi_hot_out), 32'd1);
    step(16'h0004, 1'b0, 1'b1, 1'b1);
    check("onehot_single", 32'(multi_hot_out), 32'd0);
`endif

    // Back-to-back random mix with mode switching
    for (int n = 0; n < 40; n++) begin
      step(N'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
